// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus-level constants and the
// register-pointer advance helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    REGPTR,
    ACK_PTR,
    WR_BYTE,
    ACK_WR,
    RD_BYTE,
    RD_ACK
  } i2c_state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// scl/sda input synchronisers with START/STOP and scl edge detection;
// shareable between the I2C target and master.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Idle bus is high, so synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_s     = scl_q[SYNC_STAGES-1];
  assign sda_s     = sda_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an internal register file and a local host read port.
// Optional macro I2C_SLAVE_AUTOINC_EN: pointer auto-increments (with wrap) per byte.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h01,
  parameter int         DEPTH       = 32,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  output logic          busy,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          addr_err,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata
);

  i2c_state_t    state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [7:0]    sh, sh_n;
  logic [AW-1:0] ptr, ptr_n, ptr_adv;
  logic          sda_oe, oe_n;
  logic          busy_n, rw, rw_n;
  logic          wv_n, ae_n, we;
  logic [AW-1:0] wa_n;
  logic [7:0]    wd_n;
  logic [7:0]    rx_byte;
  logic          ptr_ok;
  logic [7:0]    regs [DEPTH];

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda        = sda_oe ? 1'b0 : 1'bz;
  assign host_rdata = regs[host_addr];
  assign rx_byte    = {sh[6:0], sda_s};
  assign ptr_ok     = ({1'b0, rx_byte} < 9'(DEPTH));

`ifdef I2C_SLAVE_AUTOINC_EN
  assign ptr_adv = AW'(ptr_next(32'(ptr), DEPTH));
`else
  assign ptr_adv = ptr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rw       <= RW_WRITE;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      ptr      <= ptr_n;
      sda_oe   <= oe_n;
      busy     <= busy_n;
      rw       <= rw_n;
      wr_valid <= wv_n;
      wr_addr  <= wa_n;
      wr_data  <= wd_n;
      addr_err <= ae_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) regs[i] <= '0;
    end else if (we) begin
      regs[ptr] <= rx_byte;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    ptr_n   = ptr;
    oe_n    = sda_oe;
    busy_n  = busy;
    rw_n    = rw;
    wv_n    = 1'b0;
    ae_n    = 1'b0;
    wa_n    = wr_addr;
    wd_n    = wr_data;
    we      = 1'b0;

    if (start_det) begin
      state_n = DEVADDR;
      cnt_n   = '0;
    end else if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scl_fall) oe_n = 1'b0;
        end

        DEVADDR, REGPTR, WR_BYTE: begin
          if (scl_rise) begin
            sh_n  = rx_byte;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n = '0;
              case (state)
                DEVADDR: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_n = ACK_DEV;
                    busy_n  = 1'b1;
                    rw_n    = rx_byte[0];
                  end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                  end
                end
                REGPTR: begin
                  if (ptr_ok) begin
                    ptr_n   = rx_byte[AW-1:0];
                    state_n = ACK_PTR;
                  end else begin
                    ae_n    = 1'b1;
                    state_n = IDLE;
                  end
                end
                default: begin
                  we      = 1'b1;
                  wv_n    = 1'b1;
                  wa_n    = ptr;
                  wd_n    = rx_byte;
                  ptr_n   = ptr_adv;
                  state_n = ACK_WR;
                end
              endcase
            end
          end
        end

        // cnt: 0 = waiting for the fall that opens the ACK slot,
        // 1 = ACK driven, 2 = ACK clock high, next fall closes the slot.
        ACK_DEV, ACK_PTR, ACK_WR: begin
          if (scl_fall && cnt == 4'd0) begin
            oe_n  = (ACK == 1'b0);
            cnt_n = 4'd1;
          end else if (scl_rise) begin
            cnt_n = 4'd2;
          end else if (scl_fall && cnt == 4'd2) begin
            oe_n  = 1'b0;
            cnt_n = '0;
            if (state == ACK_DEV && rw == RW_READ) begin
              state_n = RD_BYTE;
              sh_n    = regs[ptr];
              oe_n    = ~regs[ptr][7];
            end else if (state == ACK_DEV) begin
              state_n = REGPTR;
            end else begin
              state_n = WR_BYTE;
            end
          end
        end

        RD_BYTE: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              cnt_n   = '0;
              state_n = RD_ACK;
            end else begin
              sh_n = {sh[6:0], 1'b0};
              oe_n = ~sh[6];
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            ptr_n = ptr_adv;
            if (sda_s == ACK) begin
              sh_n  = regs[ptr_adv];
              cnt_n = 4'd1;
            end else begin
              state_n = IDLE;
            end
          end else if (scl_fall && cnt == 4'd1) begin
            state_n = RD_BYTE;
            cnt_n   = '0;
            oe_n    = ~sh[7];
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
Parametrised next-generation I2C target with an internal register file. Supports multi-byte bursts, repeated START and range-checked register pointers. Sits on the shared open-drain scl/sda bus next to i2c_master, one instance per device address. Adds a local host port so on-chip logic can observe I2C writes and read the register file.

Parameters:
- DEV_ADDR, 7'h01: 7-bit I2C device address this instance answers to.
- DEPTH, 32: number of 8-bit registers, 2..256; AW = $clog2(DEPTH).
- SYNC_STAGES, 2: synchroniser flops on scl/sda inputs, minimum 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- scl  in  1  I2C clock; the target never stretches the clock.
- sda  inout  1  I2C data, open-drain: driven 1'b0 or released to 1'bz, never driven 1.
- busy  out  1  high from a START addressed to DEV_ADDR until STOP, or until a START to another address.
- wr_valid  out  1  one-clk pulse when a data byte has been written to the register file.
- wr_addr  out  AW  register index of the write that raised wr_valid.
- wr_data  out  8  byte written, held until the next wr_valid.
- addr_err  out  1  one-clk pulse when a register-pointer byte is NACKed (value >= DEPTH).
- host_addr  in  AW  local read index.
- host_rdata  out  8  combinational read of regfile[host_addr].

Behaviour:
- Reset (rst=0, async): sda released, busy=0, wr_valid=0, addr_err=0, wr_addr=0, wr_data=0, pointer=0, all registers=0, FSM=IDLE.
- Inputs pass through SYNC_STAGES flops. Edge detection is done on the synchronised signals.
  - START/Sr: sda falls while scl=1.
  - STOP: sda rises while scl=1.
- sda is sampled on the synchronised scl rising edge. sda_oe changes only on the clk following the synchronised scl falling edge.
- FSM states: IDLE, DEVADDR, ACK_DEV, REGPTR, ACK_PTR, WR_BYTE, ACK_WR, RD_BYTE, RD_ACK.
  - START from any state -> DEVADDR, with the bit counter cleared. This covers Sr mid-transfer.
  - STOP from any state -> IDLE: sda released, busy=0.
  - DEVADDR: shift 8 bits MSB first. If bits[7:1]==DEV_ADDR -> ACK_DEV and drive ACK. Otherwise -> IDLE, sda untouched.
  - ACK_DEV: R/W=0 -> REGPTR; R/W=1 -> RD_BYTE, loading regfile[pointer].
  - REGPTR: shift 8 bits.
    - Value < DEPTH: pointer = value, ACK, go to WR_BYTE.
    - Value >= DEPTH: NACK (sda released), pulse addr_err, go to IDLE; pointer unchanged.
  - WR_BYTE: shift 8 bits, then ACK and go to ACK_WR. On the 8th bit's sample edge: write regfile[pointer], pulse wr_valid with wr_addr=pointer and wr_data=byte. Then advance the pointer (see Optional Feature) and go back to WR_BYTE.
  - RD_BYTE: drive shift register MSB first. At the 9th clock release sda and sample master ACK/NACK.
    - ACK: advance pointer, reload, stay in RD_BYTE.
    - NACK: -> IDLE, waiting for STOP.
- The pointer persists across transactions. A read with no pointer byte starts at the current pointer.
- Simultaneous host read and I2C write to the same index: host_rdata shows the old value in that cycle and the new value on the next.
- Reset mid-transfer releases sda immediately (async).

Optional Feature:
- Macro I2C_SLAVE_AUTOINC_EN.
- Defined: after every written or read byte, pointer = (pointer==DEPTH-1) ? 0 : pointer+1. Bursts wrap around.
- Undefined: the pointer stays fixed. Bursts repeatedly write or read the same register.

Decomposition:
- Package i2c_pkg:
  - FSM state encoding.
  - ACK=1'b0 and NACK=1'b1 constants.
  - Direction constants RW_WRITE=0 and RW_READ=1.
  - Helper function ptr_next(ptr, DEPTH).
- One natural sub-module, i2c_bus_sync: synchronisers plus START/STOP/scl-edge detection. It is shareable with i2c_master.

Test Plan:
- Single write: S 0x02 0x03 0xAB P (DEV_ADDR=1) -> ACK on all three bytes, wr_valid pulse with wr_addr=3 and wr_data=0xAB; host_addr=3 reads 0xAB.
- Burst write with AUTOINC: S 0x02 0x1F 0x11 0x22 P (DEPTH=32) -> reg31=0x11, reg0=0x22 (wrap), two wr_valid pulses.
- Combined read: S 0x02 0x05 Sr 0x03, master ACKs then NACKs -> returns reg5 then reg6, sda released after NACK, busy=0 after P.
- Out-of-range pointer: S 0x02 0x40 (DEPTH=32) -> pointer byte NACKed, addr_err pulse, no wr_valid, next read uses the old pointer.
- Two instances at DEV_ADDR=1 and 2: write to 0x04 (addr 2) -> only instance 2 ACKs and updates; instance 1 keeps busy=0 and sda released.
- Reset asserted mid read byte (sda low) -> sda=Z in the same timestep, all outputs return to reset values, registers read 0.
